// File: rtl/vx_mem_traffic_gen.sv
// rtl/vx_mem_traffic_gen.sv - write-then-read memory request generator with read-data checking
// Optional watchdog: define VX_MEM_GEN_TIMEOUT_EN
module vx_mem_traffic_gen #(
  parameter int                    ADDR_WIDTH      = 26,
  parameter int                    DATA_WIDTH      = 512,
  parameter int                    TAG_WIDTH       = 8,
  parameter int                    NUM_REQS        = 16,
  parameter int                    MAX_OUTSTANDING = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = '0,
  parameter logic [31:0]           SEED            = 32'hA5A5_0000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic                    mem_req_valid,
  output logic                    mem_req_rw,
  output logic [DATA_WIDTH/8-1:0] mem_req_byteen,
  output logic [ADDR_WIDTH-1:0]   mem_req_addr,
  output logic [DATA_WIDTH-1:0]   mem_req_data,
  output logic [TAG_WIDTH-1:0]    mem_req_tag,
  input  logic                    mem_req_ready,
  input  logic                    mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]   mem_rsp_data,
  input  logic [TAG_WIDTH-1:0]    mem_rsp_tag,
  output logic                    mem_rsp_ready,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [15:0]             err_count,
  output logic [TAG_WIDTH-1:0]    first_err_tag
);

  localparam int NWORDS = DATA_WIDTH / 32;
  localparam int IW     = $clog2(NUM_REQS + 1);
  localparam int PW     = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
  localparam int OW     = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_WAIT, S_DONE} state_t;

  state_t               r_state, w_next;
  logic [IW-1:0]        r_idx;
  logic [OW-1:0]        r_outstanding;
  logic [(1<<PW)-1:0]   r_pending;
  logic [15:0]          r_err_count;
  logic [TAG_WIDTH-1:0] r_first_err_tag;
  logic                 r_timed_out;

  logic          w_req_valid, w_req_rw, w_rsp_ready;
  logic          w_req_fire, w_rd_fire, w_rsp_fire, w_dec;
  logic          w_start_go, w_last_idx, w_tag_oob, w_rsp_err, w_timeout;
  logic [PW-1:0] w_req_slot, w_rsp_slot;
  logic [16:0]   w_err_inc, w_err_sum;

  // Line pattern: each 32-bit word is {line, word} scrambled with SEED
  function automatic logic [DATA_WIDTH-1:0] f_pattern(input logic [15:0] line);
    logic [DATA_WIDTH-1:0] v;
    v = '0;
    for (int w = 0; w < NWORDS; w++) v[w*32 +: 32] = {line, 16'(w)} ^ SEED;
    return v;
  endfunction

  assign w_start_go = start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_last_idx = (r_idx == IW'(NUM_REQS - 1));
  assign w_req_fire = w_req_valid && mem_req_ready;
  assign w_rd_fire  = w_req_fire && !w_req_rw;
  assign w_rsp_fire = mem_rsp_valid && w_rsp_ready;
  assign w_dec      = w_rsp_fire && (r_outstanding != '0);
  assign w_req_slot = PW'(r_idx);
  assign w_rsp_slot = PW'(mem_rsp_tag);
  assign w_tag_oob  = 32'(mem_rsp_tag) >= 32'(NUM_REQS);
  assign w_rsp_err  = w_tag_oob || !r_pending[w_rsp_slot] || (r_outstanding == '0) ||
                      (mem_rsp_data != f_pattern(16'(mem_rsp_tag)));
  assign w_err_sum  = {1'b0, r_err_count} + w_err_inc;

  // Request fields are forced to zero when no request is offered so idle outputs read as 0
  assign mem_req_valid  = w_req_valid;
  assign mem_req_rw     = w_req_rw;
  assign mem_req_byteen = {(DATA_WIDTH/8){w_req_valid}};
  assign mem_req_addr   = w_req_valid ? BASE_ADDR + ADDR_WIDTH'(r_idx) : '0;
  assign mem_req_data   = (w_req_valid && w_req_rw) ? f_pattern(16'(r_idx)) : '0;
  assign mem_req_tag    = w_req_valid ? TAG_WIDTH'(r_idx) : '0;
  assign mem_rsp_ready  = w_rsp_ready;
  assign err_count      = r_err_count;
  assign first_err_tag  = r_first_err_tag;

`ifdef VX_MEM_GEN_TIMEOUT_EN
  logic [15:0] r_wdog;

  function automatic logic [16:0] f_popcount(input logic [(1<<PW)-1:0] v);
    logic [16:0] n;
    n = '0;
    for (int k = 0; k < (1 << PW); k++) n = n + 17'(v[k]);
    return n;
  endfunction

  // Watchdog: restarts on any handshake, counts while reads are stuck in flight
  always_ff @(posedge clk) begin
    if (!reset || w_start_go || w_req_fire || w_rsp_fire) begin
      r_wdog <= '0;
    end else if ((r_state == S_READ || r_state == S_WAIT) && r_outstanding != '0 && r_wdog != 16'hFFFF) begin
      r_wdog <= r_wdog + 16'd1;
    end
  end

  assign w_timeout = (r_state == S_READ || r_state == S_WAIT) && (r_wdog == 16'hFFFF);
`else
  assign w_timeout = 1'b0;
`endif

  // Errors this cycle: one per bad response, plus every abandoned tag on a timeout
  always_comb begin
    w_err_inc = '0;
    if (w_rsp_fire && w_rsp_err) w_err_inc = 17'd1;
`ifdef VX_MEM_GEN_TIMEOUT_EN
    if (w_timeout) w_err_inc = w_err_inc + f_popcount(r_pending);
`endif
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state: write all lines, read them back, drain outstanding reads
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_WRITE;
      S_WRITE: if (w_req_fire && w_last_idx) w_next = S_READ;
      S_READ: begin
        if (w_timeout)                     w_next = S_DONE;
        else if (w_req_fire && w_last_idx) w_next = S_WAIT;
      end
      S_WAIT:  if (w_timeout || r_outstanding == '0) w_next = S_DONE;
      S_DONE:  if (start) w_next = S_WRITE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs decoded from registered state only, so responses never reach mem_req_* combinationally
  always_comb begin
    w_req_valid = 1'b0;
    w_req_rw    = 1'b0;
    w_rsp_ready = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    pass        = 1'b0;
    case (r_state)
      S_WRITE: begin
        w_req_valid = 1'b1;
        w_req_rw    = 1'b1;
        busy        = 1'b1;
      end
      S_READ: begin
        w_req_valid = (r_outstanding < OW'(MAX_OUTSTANDING)) && (r_idx < IW'(NUM_REQS));
        w_rsp_ready = 1'b1;
        busy        = 1'b1;
      end
      S_WAIT: begin
        w_rsp_ready = 1'b1;
        busy        = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
        pass = (r_err_count == 16'd0) && !r_timed_out;
      end
      default: ;
    endcase
  end

  // Datapath: line index, in-flight tracking, error accounting
  always_ff @(posedge clk) begin
    if (!reset || w_start_go) begin
      r_idx           <= '0;
      r_outstanding   <= '0;
      r_pending       <= '0;
      r_err_count     <= '0;
      r_first_err_tag <= '0;
      r_timed_out     <= 1'b0;
    end else begin
      if (w_req_fire) r_idx <= (r_state == S_WRITE && w_last_idx) ? '0 : r_idx + IW'(1);
      if (w_rd_fire && !w_dec)      r_outstanding <= r_outstanding + OW'(1);
      else if (!w_rd_fire && w_dec) r_outstanding <= r_outstanding - OW'(1);
      if (w_rsp_fire && !w_tag_oob) r_pending[w_rsp_slot] <= 1'b0;
      if (w_rd_fire)                r_pending[w_req_slot] <= 1'b1;
      if (w_err_inc != '0) r_err_count <= w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
      if (w_rsp_fire && w_rsp_err && r_err_count == 16'd0) r_first_err_tag <= mem_rsp_tag;
      if (w_timeout) r_timed_out <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vx_mem_traffic_gen.sv
// tb/tb_vx_mem_traffic_gen.sv - table-driven scoreboard bench for vx_mem_traffic_gen
`timescale 1ns/1ps
module tb_vx_mem_traffic_gen;

  localparam int AW = 26;
  localparam int DW = 512;
  localparam int TW = 8;
  localparam int NR = 16;
  localparam int MO = 4;
  localparam logic [31:0] SEED = 32'hA5A5_0000;
`ifdef VX_MEM_GEN_TIMEOUT_EN
  localparam int NVEC = 7;
`else
  localparam int NVEC = 6;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            start = 1'b0;
  logic            mem_req_valid, mem_req_rw;
  logic [DW/8-1:0] mem_req_byteen;
  logic [AW-1:0]   mem_req_addr;
  logic [DW-1:0]   mem_req_data;
  logic [TW-1:0]   mem_req_tag;
  logic            mem_req_ready = 1'b0;
  logic            mem_rsp_valid = 1'b0;
  logic [DW-1:0]   mem_rsp_data = '0;
  logic [TW-1:0]   mem_rsp_tag = '0;
  logic            mem_rsp_ready, busy, done, pass;
  logic [15:0]     err_count;
  logic [TW-1:0]   first_err_tag;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vx_mem_traffic_gen #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .NUM_REQS(NR),
    .MAX_OUTSTANDING(MO), .BASE_ADDR('0), .SEED(SEED)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw), .mem_req_byteen(mem_req_byteen),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_tag(mem_req_tag),
    .mem_req_ready(mem_req_ready), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .mem_rsp_tag(mem_rsp_tag), .mem_rsp_ready(mem_rsp_ready), .busy(busy), .done(done),
    .pass(pass), .err_count(err_count), .first_err_tag(first_err_tag)
  );

  typedef struct {
    int mode;        // 0 in-order, 1 reversed windows of MO
    int corrupt;     // tag whose read data is flipped, -1 none
    int drop;        // tag never answered, -1 none
    int inject;      // extra unsolicited tag, -1 none
    bit rnd;         // 50% random mem_req_ready
    bit restart_mid; // pulse start while busy
    int max_wait;
    int max_len;     // 0 = no run-length bound
    int exp_err;
    int exp_first;
    bit exp_pass;
  } vec_t;

  typedef struct {
    bit            rw;
    logic [AW-1:0] addr;
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
  } req_t;

  vec_t vecs [NVEC];
  req_t exp_q[$];
  logic [TW-1:0] rq[$];
  logic [TW-1:0] win[$];
  logic [DW-1:0] mem [0:NR-1];

  int mode = 0, corrupt_tag = -1, drop_tag = -1, inject_tag = -1;
  bit rnd_ready = 1'b0, hold = 1'b0;
  int inj_state = 0;
  int req_fires = 0, read_fires = 0, bench_out = 0;

  bit            stall_prev = 1'b0;
  bit            h_rw;
  logic [AW-1:0] h_addr;
  logic [TW-1:0] h_tag;
  logic [DW-1:0] h_data;
  logic [TW-1:0] rt;
  bit            have;
  req_t          re;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_line(input int i);
    logic [DW-1:0] v;
    for (int w = 0; w < DW/32; w++) v[w*32 +: 32] = (((i & 32'hFFFF) << 16) | (w & 32'hFFFF)) ^ SEED;
    return v;
  endfunction

  task automatic clear_resp();
    rq.delete();
    win.delete();
    exp_q.delete();
    inj_state  = 0;
    req_fires  = 0;
    read_fires = 0;
    bench_out  = 0;
    stall_prev = 1'b0;
  endtask

  task automatic fill_exp();
    req_t e;
    for (int i = 0; i < NR; i++) begin
      e.rw = 1'b1; e.addr = AW'(i); e.tag = TW'(i); e.data = exp_line(i);
      exp_q.push_back(e);
    end
    for (int i = 0; i < NR; i++) begin
      e.rw = 1'b0; e.addr = AW'(i); e.tag = TW'(i); e.data = '0;
      exp_q.push_back(e);
    end
  endtask

  // Responder and request scoreboard, acting on the falling edge
  initial forever begin
    @(negedge clk);
    if (stall_prev && mem_req_valid)
      check("stall_hold", {mem_req_rw == h_rw && mem_req_addr == h_addr && mem_req_tag == h_tag &&
                           mem_req_data == h_data}, 1);

    mem_rsp_valid = 1'b0;
    if (hold) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_tag   = TW'(1);
      mem_rsp_data  = '0;
    end else if (inject_tag >= 0 && inj_state == 1 && rq.size() == 0 && win.size() == 0 &&
                 bench_out == 0 && mem_rsp_ready) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_tag   = TW'(inject_tag);
      mem_rsp_data  = '0;
      inj_state     = 2;
    end else begin
      while (rq.size() > 0 && int'(rq[0]) == drop_tag) void'(rq.pop_front());
      if (mode == 1 && win.size() == 0 && (rq.size() >= MO || (read_fires == NR && rq.size() > 0))) begin
        win = rq;
        rq.delete();
      end
      have = 1'b0;
      if (mode == 1 && win.size() > 0) begin
        rt = win[win.size()-1]; have = 1'b1;
      end else if (mode == 0 && rq.size() > 0) begin
        rt = rq[0]; have = 1'b1;
      end
      if (have) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_tag   = rt;
        mem_rsp_data  = mem[int'(rt)] ^ DW'(int'(rt) == corrupt_tag);
        if (mem_rsp_ready) begin
          if (mode == 1) void'(win.pop_back());
          else           void'(rq.pop_front());
          bench_out--;
        end
      end
    end

    if (hold) mem_req_ready = 1'b0;
    else if (inject_tag >= 0 && inj_state < 2 && read_fires >= 8) begin
      inj_state     = 1;
      mem_req_ready = 1'b0;
    end
    else if (rnd_ready) mem_req_ready = 1'($urandom_range(0, 1));
    else mem_req_ready = 1'b1;

    if (mem_req_valid && mem_req_ready) begin
      req_fires++;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL req_extra: unexpected request tag %0h", mem_req_tag);
      end else begin
        re = exp_q.pop_front();
        check("req_rw", mem_req_rw, re.rw);
        check("req_addr", mem_req_addr, re.addr);
        check("req_tag", mem_req_tag, re.tag);
        check("req_data", mem_req_data, re.data);
        check("req_byteen", mem_req_byteen, {(DW/8){1'b1}});
      end
      if (mem_req_rw) begin
        if (mem_req_addr == AW'(5)) check("line5_word3", mem_req_data[3*32 +: 32], 32'hA5A0_0003);
        if (int'(mem_req_addr) < NR) mem[int'(mem_req_addr)] = mem_req_data;
      end else begin
        rq.push_back(mem_req_tag);
        read_fires++;
        bench_out++;
        check("outstanding_max", bench_out <= MO, 1);
      end
    end
    stall_prev = mem_req_valid && !mem_req_ready;
    h_rw = mem_req_rw; h_addr = mem_req_addr; h_tag = mem_req_tag; h_data = mem_req_data;
  end

  task automatic run_vec(input vec_t v, input int r);
    int cyc;
    @(posedge clk); #1;
    clear_resp();
    mode = v.mode; corrupt_tag = v.corrupt; drop_tag = v.drop; inject_tag = v.inject; rnd_ready = v.rnd;
    fill_exp();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check($sformatf("v%0d_busy_after_start", r), busy, 1);
    check($sformatf("v%0d_done_cleared", r), done, 0);
    check($sformatf("v%0d_first_req_latency", r), mem_req_valid, 1);
    cyc = 1;
    while (!done && cyc < v.max_wait) begin
      @(negedge clk);
      cyc++;
      start = v.restart_mid && cyc == 5;
    end
    start = 1'b0;
    check($sformatf("v%0d_done", r), done, 1);
    check($sformatf("v%0d_busy_low", r), busy, 0);
    check($sformatf("v%0d_pass", r), pass, v.exp_pass);
    check($sformatf("v%0d_err_count", r), err_count, v.exp_err);
    check($sformatf("v%0d_first_err_tag", r), first_err_tag, v.exp_first);
    check($sformatf("v%0d_req_fires", r), req_fires, 2*NR);
    check($sformatf("v%0d_scoreboard_empty", r), exp_q.size(), 0);
    if (v.max_len > 0) check($sformatf("v%0d_run_length", r), cyc <= v.max_len, 1);
  endtask

  initial begin
    int cyc;
    vec_t rv;
    vecs[0] = '{0, -1, -1, -1, 1'b0, 1'b0, 200, 35, 0, 0, 1'b1};
    vecs[1] = '{1, -1, -1, -1, 1'b0, 1'b0, 300, 0, 0, 0, 1'b1};
    vecs[2] = '{0, 7, -1, -1, 1'b0, 1'b0, 200, 35, 1, 7, 1'b0};
    vecs[3] = '{0, -1, -1, -1, 1'b1, 1'b0, 600, 0, 0, 0, 1'b1};
    vecs[4] = '{0, -1, -1, 20, 1'b0, 1'b0, 300, 0, 1, 20, 1'b0};
    vecs[5] = '{1, 3, -1, -1, 1'b1, 1'b0, 800, 0, 1, 3, 1'b0};
`ifdef VX_MEM_GEN_TIMEOUT_EN
    vecs[6] = '{0, -1, 2, -1, 1'b0, 1'b0, 70000, 0, 1, 0, 1'b0};
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_valid", mem_req_valid, 0);
    check("rst_rsp_ready", mem_rsp_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err_count", err_count, 0);
    check("rst_first_err_tag", first_err_tag, 0);
    check("rst_req_fields", {mem_req_rw, mem_req_addr, mem_req_tag, mem_req_byteen}, 0);
    check("rst_req_data", mem_req_data, 0);
    @(posedge clk); #1;
    reset = 1'b1;

    for (int r = 0; r < NVEC; r++) run_vec(vecs[r], r);

    // Reset in the middle of the read phase, then a fresh run with an ignored start while busy
    @(posedge clk); #1;
    clear_resp();
    mode = 0; corrupt_tag = -1; drop_tag = -1; inject_tag = -1; rnd_ready = 1'b0;
    fill_exp();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (read_fires < 3 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("midrst_reached_read", read_fires >= 3, 1);
    @(posedge clk); #1;
    hold  = 1'b1;
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_req_valid", mem_req_valid, 0);
    check("midrst_rsp_ready", mem_rsp_ready, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done_pass", {done, pass}, 0);
    check("midrst_err_count", err_count, 0);
    check("midrst_req_fields", {mem_req_rw, mem_req_addr, mem_req_tag, mem_req_byteen}, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("stale_rsp_ready", mem_rsp_ready, 0);
    check("stale_err_count", err_count, 0);
    check("stale_busy", busy, 0);
    @(posedge clk); #1;
    hold = 1'b0;
    rv = '{0, -1, -1, -1, 1'b0, 1'b1, 200, 35, 0, 0, 1'b1};
    run_vec(rv, 99);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vx_mem_traffic_gen.md
Name: vx_mem_traffic_gen

Overview:
- Memory-request initiator that stands in for the Vortex core on the mem_req/mem_rsp interface.
- Drives a memory responder (e.g. VX_to_mem_bypass) with a deterministic sequence:
  - NUM_REQS line writes, then NUM_REQS reads of the same lines.
  - Read data is checked against the written pattern; pass/fail and an error count are reported.
- Used in tb/ to bring up and regress memory-side models without the full core.

Parameters:
- ADDR_WIDTH, 26: line-address width of mem_req_addr.
- DATA_WIDTH, 512: line data width; multiple of 32.
- TAG_WIDTH, 8: request/response tag width; must be ≥ $clog2(NUM_REQS).
- NUM_REQS, 16: lines written and read per run; ≥ 1.
- MAX_OUTSTANDING, 4: maximum reads in flight; 1..NUM_REQS.
- BASE_ADDR, 0: first line address.
- SEED, 32'hA5A5_0000: pattern XOR seed.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse; begins a run when idle
- mem_req_valid  out  1  request valid
- mem_req_rw  out  1  1 = write, 0 = read
- mem_req_byteen  out  DATA_WIDTH/8  byte enables
- mem_req_addr  out  ADDR_WIDTH  line address
- mem_req_data  out  DATA_WIDTH  write data
- mem_req_tag  out  TAG_WIDTH  request tag
- mem_req_ready  in  1  responder accepts the request
- mem_rsp_valid  in  1  read response valid
- mem_rsp_data  in  DATA_WIDTH  read data
- mem_rsp_tag  in  TAG_WIDTH  response tag
- mem_rsp_ready  out  1  generator accepts the response
- busy  out  1  run in progress
- done  out  1  run complete; held until next start
- pass  out  1  valid when done; 1 = zero errors
- err_count  out  16  mismatched or unexpected responses; saturates at 16'hFFFF
- first_err_tag  out  TAG_WIDTH  tag of first error; 0 if none

Behaviour:
- Reset (reset == 0 at posedge clk):
  - State is IDLE.
  - All outputs are 0, including mem_req_valid, mem_rsp_ready, busy, done, pass, err_count and first_err_tag.
  - Counters are cleared and the expected-tag vector is cleared.
- Reset asserted mid-run aborts the run the next cycle. In-flight responses that arrive after reset is released are ignored: mem_rsp_ready is 0 in IDLE.
- Handshakes:
  - A request fires when mem_req_valid && mem_req_ready.
  - A response fires when mem_rsp_valid && mem_rsp_ready.
  - While mem_req_valid is high and not accepted, addr/data/tag/rw/byteen are held stable.
- Pattern: for line i, 32-bit word w = {i[15:0], w[15:0]} ^ SEED. Byteen is all ones for every request.
- Each request uses addr = BASE_ADDR + i and tag = i, zero-extended to TAG_WIDTH.
- State machine:
  - IDLE: start → WRITE. Clear done, pass, err_count, first_err_tag and the index; busy goes to 1. start is ignored while busy.
  - WRITE:
    - mem_req_valid = 1, rw = 1.
    - The index increments on each fire.
    - After write NUM_REQS-1 fires → READ with index = 0.
    - Writes produce no response.
  - READ:
    - mem_req_valid = 1 and rw = 0 while outstanding < MAX_OUTSTANDING and index < NUM_REQS.
    - On each fire: set pending[tag] and increment the index.
    - mem_rsp_ready = 1.
    - After the last read fires → WAIT.
  - WAIT: mem_req_valid = 0, mem_rsp_ready = 1. When outstanding == 0 → DONE.
  - DONE:
    - done = 1, busy = 0, pass = (err_count == 0).
    - On start → behave as IDLE+start in the same cycle.
- Outstanding counter:
  - +1 on read request fire, −1 on response fire.
  - Simultaneous fire leaves it unchanged.
  - A response fire with outstanding == 0 does not decrement; it is counted as an error.
- Response check, in READ and WAIT states:
  - Responses may return out of order.
  - Error if pending[tag] == 0, tag ≥ NUM_REQS, or data ≠ pattern(tag).
  - A valid-tag response clears pending[tag].
  - On the first error, first_err_tag latches mem_rsp_tag.
  - Response checking uses no combinational path from mem_rsp_* to mem_req_*.
- Latency: the first request is valid the cycle after start is sampled.
- Maximum run length with a zero-stall responder: 2·NUM_REQS + responder latency + 2 cycles.

Optional Feature:
- Macro: VX_MEM_GEN_TIMEOUT_EN.
- Defined:
  - Adds a 16-bit watchdog, reset on any response fire or request fire.
  - It increments each cycle in READ/WAIT while outstanding > 0.
  - When it reaches 16'hFFFF, the generator goes to DONE with pass = 0.
  - err_count increments by the count of still-pending tags, saturating.
- Undefined:
  - No watchdog logic; the generator waits indefinitely in WAIT.

Test Plan:
- Zero-latency in-order responder, defaults, one start pulse → 16 writes then 16 reads; done = 1, pass = 1, err_count = 0. Addresses 0..15; word 3 of line 5 reads 32'hA5A0_0003 ^ pattern check.
- Responder returns tags in reverse order within windows of 4 → pass = 1; outstanding never exceeds 4 (assertion).
- Responder corrupts data for tag 7 → err_count = 1, first_err_tag = 7, pass = 0.
- mem_req_ready toggled pseudo-randomly at 50% → request fields stable while stalled; exactly 32 request fires; pass = 1.
- Responder injects an extra response with tag 20 → err_count = 1, first_err_tag = 20. Reset pulsed mid-READ → all outputs 0 next cycle; a new start completes with pass = 1.
- With VX_MEM_GEN_TIMEOUT_EN, responder drops tag 2 → done after 65535 idle cycles, pass = 0, err_count = 1.
